// File: rtl/chnl_arbiter_pkg.sv
// Shared definitions for the channel arbiter: index-width helper and FSM encoding.
package chnl_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/chnl_arbiter_if.sv
// Producer-side and consumer-side stream signals of the channel arbiter.
interface chnl_arbiter_if #(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IDW   = chnl_pkg::clog2(N)
) ();

    logic [N-1:0]       i_val;
    logic [N-1:0]       i_rdy;
    logic [N-1:0]       i_last;
    logic [N*WIDTH-1:0] i_data;
    logic               o_val;
    logic               o_rdy;
    logic               o_last;
    logic [IDW-1:0]     o_id;
    logic [WIDTH-1:0]   o_data;

    modport slave (
        input  i_val, i_last, i_data, o_rdy,
        output i_rdy, o_val, o_last, o_id, o_data
    );

    modport master (
        output i_val, i_last, i_data, o_rdy,
        input  i_rdy, o_val, o_last, o_id, o_data
    );

endinterface

// File: rtl/chnl_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first requester at or after ptr, wrapping modulo N.
module rr_pick
    import chnl_pkg::*;
#(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] idx
);

    int unsigned    k;
    logic [IDW-1:0] kk;
    logic           found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        kk    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            k = 32'(ptr) + i;
            if (k >= N) begin
                k = k - N;
            end
            kk = k[IDW-1:0];
            if (!found && req[kk]) begin
                found   = 1'b1;
                gnt[kk] = 1'b1;
                idx     = kk;
            end
        end
    end

endmodule

// File: rtl/chnl_arbiter.sv
// Packet-level round-robin arbiter: N valid/ready channels onto one registered output stage.
module chnl_arbiter
    import chnl_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 32
) (
    input logic           clk,
    input logic           rst,
    chnl_arbiter_if.slave bus
);

    localparam int unsigned IDW = clog2(N);

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   owner_q, owner_d;
    logic             o_val_q, o_last_q;
    logic [IDW-1:0]   o_id_q;
    logic [WIDTH-1:0] o_data_q;

    logic             stage_en;
    logic [N-1:0]     pick_gnt;
    logic [IDW-1:0]   pick_idx;
    logic [N-1:0]     rdy;
    logic [IDW-1:0]   sel_id;
    logic             accept;
    logic             acc_last;
    logic [WIDTH-1:0] acc_data;

    function automatic logic [IDW-1:0] inc_mod(input logic [IDW-1:0] x);
        return (32'(x) == N - 1) ? '0 : x + 1'b1;
    endfunction

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req (bus.i_val),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    assign stage_en = bus.o_rdy || !o_val_q;
    assign acc_data = bus.i_data[32'(sel_id) * WIDTH +: WIDTH];

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        rdy      = '0;
        sel_id   = owner_q;
        accept   = 1'b0;
        acc_last = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                sel_id = pick_idx;
                rdy    = stage_en ? pick_gnt : '0;
            end
            ST_LOCKED: begin
                // Owner keeps the output even while it has nothing to send.
                rdy[owner_q] = stage_en;
            end
            default: ;
        endcase

        if (rst) begin
            rdy = '0;
        end
        accept   = |(bus.i_val & rdy);
        acc_last = bus.i_last[sel_id];

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (acc_last) begin
                        ptr_d = inc_mod(sel_id);
                    end else begin
                        state_d = ST_LOCKED;
                        owner_d = sel_id;
                    end
                end
            end
            ST_LOCKED: begin
                if (accept && acc_last) begin
                    state_d = ST_IDLE;
                    ptr_d   = inc_mod(owner_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            o_val_q  <= 1'b0;
            o_last_q <= 1'b0;
            o_id_q   <= '0;
            o_data_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            if (accept) begin
                o_val_q  <= 1'b1;
                o_last_q <= acc_last;
                o_id_q   <= sel_id;
                o_data_q <= acc_data;
            end else if (stage_en) begin
                o_val_q <= 1'b0;
            end
        end
    end

    assign bus.i_rdy  = rdy;
    assign bus.o_val  = o_val_q;
    assign bus.o_last = o_last_q;
    assign bus.o_id   = o_id_q;
    assign bus.o_data = o_data_q;

endmodule

// File: tb/tb_chnl_arbiter.sv
// Directed bench for chnl_arbiter with per-channel source queues and an output scoreboard.
module tb_chnl_arbiter;
    import chnl_pkg::*;

    localparam int unsigned N     = 4;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned IDW   = clog2(N);

    typedef struct packed {
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] data;
        logic             last;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    chnl_arbiter_if #(.N(N), .WIDTH(WIDTH)) bus ();

    chnl_arbiter #(
        .N     (N),
        .WIDTH (WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    beat_t            exp_q[$];
    logic [WIDTH-1:0] src_data [N][64];
    logic             src_last [N][64];
    int               src_head [N];
    int               src_tail [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive();
        for (int c = 0; c < N; c++) begin
            if (src_head[c] < src_tail[c]) begin
                bus.i_val[c]                = 1'b1;
                bus.i_last[c]               = src_last[c][src_head[c]];
                bus.i_data[c*WIDTH +: WIDTH] = src_data[c][src_head[c]];
            end else begin
                bus.i_val[c]                = 1'b0;
                bus.i_last[c]               = 1'b0;
                bus.i_data[c*WIDTH +: WIDTH] = '0;
            end
        end
    endtask

    task automatic src_push(input int c, input logic [WIDTH-1:0] d, input logic l);
        src_data[c][src_tail[c]] = d;
        src_last[c][src_tail[c]] = l;
        src_tail[c]++;
        drive();
    endtask

    task automatic exp_push(input int c, input logic [WIDTH-1:0] d, input logic l);
        beat_t b;
        b.id   = IDW'(c);
        b.data = d;
        b.last = l;
        exp_q.push_back(b);
    endtask

    // One clock: sample handshakes just before the edge, advance sources just after.
    task automatic tick();
        logic [N-1:0] acc;
        beat_t        b;
        #1;
        if (rst === 1'b0) begin
            chk("rdy_onehot0", 64'($onehot0(bus.i_rdy)), 64'd1);
        end
        acc = bus.i_val & bus.i_rdy;
        if (bus.o_val === 1'b1 && bus.o_rdy === 1'b1) begin
            chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                b = exp_q.pop_front();
                chk("out_id", 64'(bus.o_id), 64'(b.id));
                chk("out_data", 64'(bus.o_data), 64'(b.data));
                chk("out_last", 64'(bus.o_last), 64'(b.last));
            end
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < N; c++) begin
            if (acc[c] === 1'b1) begin
                src_head[c]++;
            end
        end
        drive();
        #1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    logic [3:0]       pat;
    logic             hold;
    logic [WIDTH-1:0] held;

    initial begin
        rst        = 1'b1;
        bus.o_rdy  = 1'b1;
        bus.i_val  = '0;
        bus.i_last = '0;
        bus.i_data = '0;
        for (int c = 0; c < N; c++) begin
            src_head[c] = 0;
            src_tail[c] = 0;
        end

        // Reset with every channel requesting; then single-beat round robin from channel 0.
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < N; c++) begin
                src_push(c, WIDTH'(32'h100 * c + r + 1), 1'b1);
                exp_push(c, WIDTH'(32'h100 * c + r + 1), 1'b1);
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_rdy", 64'(bus.i_rdy), 64'd0);
            chk("rst_oval", 64'(bus.o_val), 64'd0);
        end
        rst = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("fair_no_bubble", 64'(bus.o_val), 64'd1);
            tick();
        end
        drain("fair_drain", 20);

        // Channel 1 holds the output for its 3-beat packet; channel 2 follows without a bubble.
        src_push(1, 32'hA1, 1'b0);
        src_push(1, 32'hA2, 1'b0);
        src_push(1, 32'hA3, 1'b1);
        src_push(2, 32'hB1, 1'b1);
        exp_push(1, 32'hA1, 1'b0);
        exp_push(1, 32'hA2, 1'b0);
        exp_push(1, 32'hA3, 1'b1);
        exp_push(2, 32'hB1, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("lock_no_bubble", 64'(bus.o_val), 64'd1);
            tick();
        end
        drain("lock_drain", 20);

        // Owner (channel 3) stalls mid-packet; channel 0 must wait, then wins after the wrap.
        src_push(3, 32'hC1, 1'b0);
        src_push(0, 32'hD1, 1'b1);
        exp_push(3, 32'hC1, 1'b0);
        tick();
        for (int j = 0; j < 5; j++) begin
            chk("stall_rdy0", 64'(bus.i_rdy[0]), 64'd0);
            chk("stall_oval", 64'(bus.o_val), 64'(j == 0));
            tick();
        end
        exp_push(3, 32'hC2, 1'b0);
        exp_push(3, 32'hC3, 1'b1);
        exp_push(0, 32'hD1, 1'b1);
        src_push(3, 32'hC2, 1'b0);
        src_push(3, 32'hC3, 1'b1);
        drain("stall_drain", 20);

        // Backpressure on a 4-beat packet from channel 1.
        pat = 4'b1001;
        for (int k = 1; k <= 4; k++) begin
            src_push(1, WIDTH'(32'hE0 + k), 1'(k == 4));
            exp_push(1, WIDTH'(32'hE0 + k), 1'(k == 4));
        end
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            bus.o_rdy = pat[i % 4];
            hold      = (bus.o_val === 1'b1) && !bus.o_rdy;
            held      = bus.o_data;
            tick();
            if (hold) begin
                chk("bp_hold_data", 64'(bus.o_data), 64'(held));
            end
        end
        bus.o_rdy = 1'b1;
        drain("bp_drain", 10);
        chk("bp_src_empty", 64'(src_head[1]), 64'(src_tail[1]));

        // Reset during a channel-2 packet; afterwards the pointer is back at 0.
        src_push(2, 32'hF1, 1'b0);
        src_push(2, 32'hF2, 1'b0);
        src_push(2, 32'hF3, 1'b1);
        exp_push(2, 32'hF1, 1'b0);
        tick();
        rst = 1'b1;
        src_push(1, 32'h61, 1'b1);
        tick();
        chk("mrst_oval", 64'(bus.o_val), 64'd0);
        chk("mrst_rdy", 64'(bus.i_rdy), 64'd0);
        rst = 1'b0;
        exp_push(1, 32'h61, 1'b1);
        exp_push(2, 32'hF2, 1'b0);
        exp_push(2, 32'hF3, 1'b1);
        drain("mrst_drain", 20);

        tick();
        chk("idle_rdy", 64'(bus.i_rdy), 64'd0);
        chk("idle_oval", 64'(bus.o_val), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
